// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared fetch-core definitions: widths, reset vector default and the return-queue entry layout.
package instruction_fetch_sequencer_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              predict;
    logic [ADDR_W-1:0] target;
    logic [INST_W-1:0] inst;
    logic              data_valid;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_sequencer_fetch_return_queue.sv
// In-order return queue: entries allocated at issue, filled by memory responses, popped at delivery.
module instruction_fetch_sequencer_fetch_return_queue
  import instruction_fetch_sequencer_pkg::*;
#(
  parameter int unsigned P_DEPTH   = 4,
  parameter int unsigned P_DEPTH_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 alloc,
  input  logic [ADDR_W-1:0]    alloc_pc,
  input  logic                 alloc_predict,
  input  logic [ADDR_W-1:0]    alloc_target,
  input  logic                 fill,
  input  logic [INST_W-1:0]    fill_inst,
  input  logic                 pop,
  output fetch_entry_t         head,
  output logic [P_DEPTH_W:0]   occupancy
);

  fetch_entry_t               entry_q [P_DEPTH];
  fetch_entry_t               entry_d [P_DEPTH];
  logic [P_DEPTH_W-1:0]       alloc_ptr_q, alloc_ptr_d;
  logic [P_DEPTH_W-1:0]       fill_ptr_q, fill_ptr_d;
  logic [P_DEPTH_W-1:0]       pop_ptr_q, pop_ptr_d;
  logic [P_DEPTH_W:0]         occ_q, occ_d;

  always_comb begin
    entry_d     = entry_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    pop_ptr_d   = pop_ptr_q;
    occ_d       = occ_q;
    if (clear) begin
      for (int unsigned i = 0; i < P_DEPTH; i++) begin
        entry_d[P_DEPTH_W'(i)].data_valid = 1'b0;
      end
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      pop_ptr_d   = '0;
      occ_d       = '0;
    end else begin
      // Popped slots drop their valid so a stale fill never looks deliverable on the next lap.
      if (pop) begin
        entry_d[pop_ptr_q].data_valid = 1'b0;
        pop_ptr_d = pop_ptr_q + P_DEPTH_W'(1);
      end
      if (fill) begin
        entry_d[fill_ptr_q].inst       = fill_inst;
        entry_d[fill_ptr_q].data_valid = 1'b1;
        fill_ptr_d = fill_ptr_q + P_DEPTH_W'(1);
      end
      if (alloc) begin
        entry_d[alloc_ptr_q] = '{pc: alloc_pc, predict: alloc_predict, target: alloc_target,
                                 inst: '0, data_valid: 1'b0};
        alloc_ptr_d = alloc_ptr_q + P_DEPTH_W'(1);
      end
      occ_d = occ_q + (P_DEPTH_W+1)'(alloc) - (P_DEPTH_W+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < P_DEPTH; i++) begin
        entry_q[P_DEPTH_W'(i)] <= '0;
      end
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      pop_ptr_q   <= '0;
      occ_q       <= '0;
    end else begin
      entry_q     <= entry_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      pop_ptr_q   <= pop_ptr_d;
      occ_q       <= occ_d;
    end
  end

  assign head      = entry_q[pop_ptr_q];
  assign occupancy = occ_q;

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Fetch engine: holds the PC, issues word requests, tracks discards across redirects and delivers in order.
module instruction_fetch_sequencer
  import instruction_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0]  P_RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned  P_DEPTH    = 4,
  parameter int unsigned  P_DEPTH_W  = 2
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic        iEVENT_START,
  input  logic [31:0] iEVENT_PC,
  output logic        oMEM_REQ,
  output logic [31:0] oMEM_ADDR,
  input  logic        iMEM_BUSY,
  input  logic        iMEM_VALID,
  input  logic [31:0] iMEM_DATA,
  input  logic        iBP_HIT,
  input  logic [31:0] iBP_TARGET,
  output logic        oNEXT_INST_VALID,
  output logic        oNEXT_BRANCH_PREDICT,
  output logic [31:0] oNEXT_BRANCH_PREDICT_ADDR,
  output logic [31:0] oNEXT_INST,
  output logic [31:0] oNEXT_PC,
  input  logic        iNEXT_FETCH_STOP,
  input  logic        iNEXT_LOCK
);

  localparam int unsigned CNT_W = P_DEPTH_W + 2;

  logic              run_q, run_d;
  logic [31:0]       pc_q, pc_d;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;

  fetch_entry_t      head;
  logic [P_DEPTH_W:0] occupancy;
  logic              flush_c, mem_req_c, accept_c, resp_drop_c, resp_fill_c, pop_c;

  // run_q holds issue off until the first clock after reset release.
  assign flush_c     = iEVENT_START || iRESET_SYNC;
  assign mem_req_c   = run_q && !flush_c && !iNEXT_FETCH_STOP
                       && (occupancy < (P_DEPTH_W+1)'(P_DEPTH));
  assign accept_c    = mem_req_c && !iMEM_BUSY;
  assign resp_drop_c = iMEM_VALID && (discard_q != '0);
  assign resp_fill_c = iMEM_VALID && (discard_q == '0) && (outstanding_q != '0);
  assign pop_c       = head.data_valid && !iNEXT_LOCK && !flush_c;

  always_comb begin
    run_d         = 1'b1;
    pc_d          = pc_q;
    discard_d     = discard_q - CNT_W'(resp_drop_c);
    outstanding_d = outstanding_q - CNT_W'(resp_fill_c);
    if (flush_c) begin
      // Everything still in flight after this cycle's response becomes discard debt.
      discard_d     = discard_d + outstanding_d;
      outstanding_d = '0;
      pc_d          = iRESET_SYNC ? P_RESET_PC : iEVENT_PC;
    end else if (accept_c) begin
      outstanding_d = outstanding_d + CNT_W'(1);
      pc_d          = iBP_HIT ? iBP_TARGET : pc_q + PC_STEP;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      run_q         <= 1'b0;
      pc_q          <= P_RESET_PC;
      discard_q     <= '0;
      outstanding_q <= '0;
    end else begin
      run_q         <= run_d;
      pc_q          <= pc_d;
      discard_q     <= discard_d;
      outstanding_q <= outstanding_d;
    end
  end

  instruction_fetch_sequencer_fetch_return_queue #(
    .P_DEPTH   (P_DEPTH),
    .P_DEPTH_W (P_DEPTH_W)
  ) u_queue (
    .clk           (iCLOCK),
    .rst_n         (inRESET),
    .clear         (flush_c),
    .alloc         (accept_c),
    .alloc_pc      (pc_q),
    .alloc_predict (iBP_HIT),
    .alloc_target  (iBP_TARGET),
    .fill          (resp_fill_c),
    .fill_inst     (iMEM_DATA),
    .pop           (pop_c),
    .head          (head),
    .occupancy     (occupancy)
  );

  // A response with nothing outstanding and nothing to discard is a memory-side protocol error.
  assert property (@(posedge iCLOCK) disable iff (!inRESET)
                   iMEM_VALID |-> (discard_q != '0 || outstanding_q != '0));

  assign oMEM_REQ                  = mem_req_c;
  assign oMEM_ADDR                 = pc_q;
  assign oNEXT_INST_VALID          = pop_c;
  assign oNEXT_BRANCH_PREDICT      = head.predict;
  assign oNEXT_BRANCH_PREDICT_ADDR = head.target;
  assign oNEXT_INST                = head.inst;
  assign oNEXT_PC                  = head.pc;

endmodule
